// File: rtl/memory_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memory_port_arbiter_pkg : shared types for the fetch/data memory arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package memory_port_arbiter_pkg;

  localparam int unsigned NUM_REQUESTERS = 2;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_RESP_FETCH   = 2'd1,
    ST_RESP_DATA_RD = 2'd2,
    ST_RESP_DATA_WR = 2'd3
  } state_e;

  // Requester id doubles as the bit index into the req/grant vectors.
  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

endpackage
`default_nettype wire

// File: rtl/round_robin_arbiter2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// round_robin_arbiter2 : two-way arbiter, ties go to whoever was not last
// Revision: 1.0
// ---------------------------------------------------------------------------
module round_robin_arbiter2
  import memory_port_arbiter_pkg::*;
(
  input  logic [NUM_REQUESTERS-1:0] req,
  input  req_id_e                   last,
  output logic [NUM_REQUESTERS-1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == REQ_FETCH) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memory_port_arbiter : shares one synchronous single-port RAM between the
// instruction-fetch and data ports with round-robin tie breaking.
// Revision: 1.0
// ---------------------------------------------------------------------------
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic                  fetch_grant,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  data_req,
  input  logic                  data_write_en,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] data_write_value,
  output logic                  data_grant,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_read_value,
  output logic                  mem_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_value,
  input  logic [DATA_WIDTH-1:0] mem_read_value
);

  state_e  state_q, state_d;
  req_id_e last_grant_q, last_grant_d;

  logic [NUM_REQUESTERS-1:0] req_w;
  logic [NUM_REQUESTERS-1:0] grant_w;

  // Requests are masked while reset is high so no command reaches the RAM.
  assign req_w = {data_req, fetch_req} & {NUM_REQUESTERS{~reset}};

  round_robin_arbiter2 u_rr (
    .req   (req_w),
    .last  (last_grant_q),
    .grant (grant_w)
  );

  assign fetch_grant     = grant_w[REQ_FETCH];
  assign data_grant      = grant_w[REQ_DATA];
  assign mem_en          = fetch_grant | data_grant;
  assign mem_write_en    = data_grant & data_write_en;
  assign mem_address     = data_grant  ? data_address  :
                           fetch_grant ? fetch_address : '0;
  assign mem_write_value = mem_write_en ? data_write_value : '0;

  assign fetch_valid     = (state_q == ST_RESP_FETCH);
  assign fetch_data      = fetch_valid ? mem_read_value : '0;
  assign data_valid      = (state_q == ST_RESP_DATA_RD) || (state_q == ST_RESP_DATA_WR);
  assign data_read_value = (state_q == ST_RESP_DATA_RD) ? mem_read_value : '0;

  always_comb begin
    state_d      = ST_IDLE;
    last_grant_d = last_grant_q;
    if (data_grant) begin
      state_d      = data_write_en ? ST_RESP_DATA_WR : ST_RESP_DATA_RD;
      last_grant_d = REQ_DATA;
    end else if (fetch_grant) begin
      state_d      = ST_RESP_FETCH;
      last_grant_d = REQ_FETCH;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_FETCH;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_memory_port_arbiter : directed scoreboard bench with a behavioural RAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_memory_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_req, data_req, data_write_en;
  logic [AW-1:0] fetch_address, data_address;
  logic [DW-1:0] data_write_value;
  logic          fetch_grant, fetch_valid, data_grant, data_valid;
  logic [DW-1:0] fetch_data, data_read_value;
  logic          mem_en, mem_write_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_value, mem_read_value;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic          fv;
    logic [DW-1:0] fd;
    logic          dv;
    logic [DW-1:0] dd;
  } resp_t;

  resp_t sbq[$];

  always #5 clock = ~clock;

  memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_req        (fetch_req),
    .fetch_address    (fetch_address),
    .fetch_grant      (fetch_grant),
    .fetch_valid      (fetch_valid),
    .fetch_data       (fetch_data),
    .data_req         (data_req),
    .data_write_en    (data_write_en),
    .data_address     (data_address),
    .data_write_value (data_write_value),
    .data_grant       (data_grant),
    .data_valid       (data_valid),
    .data_read_value  (data_read_value),
    .mem_en           (mem_en),
    .mem_write_en     (mem_write_en),
    .mem_address      (mem_address),
    .mem_write_value  (mem_write_value),
    .mem_read_value   (mem_read_value)
  );

  // Behavioural RAM: unwritten words read back a fixed address-derived pattern.
  logic [DW-1:0] ram [0:255];
  bit   [255:0]  wr_seen;

  function automatic logic [DW-1:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {24'hC0FFEE, a};
  endfunction

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_write_en) begin
        ram[mem_address[7:0]]     <= mem_write_value;
        wr_seen[mem_address[7:0]] <= 1'b1;
      end else begin
        mem_read_value <= wr_seen[mem_address[7:0]] ? ram[mem_address[7:0]]
                                                    : init_word(mem_address[7:0]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".fetch_grant"},     32'(fetch_grant),     0);
    chk({tag, ".fetch_valid"},     32'(fetch_valid),     0);
    chk({tag, ".fetch_data"},      fetch_data,           0);
    chk({tag, ".data_grant"},      32'(data_grant),      0);
    chk({tag, ".data_valid"},      32'(data_valid),      0);
    chk({tag, ".data_read_value"}, data_read_value,      0);
    chk({tag, ".mem_en"},          32'(mem_en),          0);
    chk({tag, ".mem_write_en"},    32'(mem_write_en),    0);
    chk({tag, ".mem_address"},     mem_address,          0);
    chk({tag, ".mem_write_value"}, mem_write_value,      0);
  endtask

  task automatic push_idle();
    resp_t r;
    r.fv = 1'b0; r.fd = '0; r.dv = 1'b0; r.dd = '0;
    sbq.push_back(r);
  endtask

  // One bus cycle: drive just after the rising edge, check at the falling edge.
  // eg = expected {data_grant, fetch_grant}; ed = expected read word if granted.
  task automatic step(input string tag,
                      input logic fr, input logic [AW-1:0] fa,
                      input logic dr, input logic dwe,
                      input logic [AW-1:0] da, input logic [DW-1:0] dwv,
                      input logic [1:0] eg, input logic [DW-1:0] ed);
    resp_t e, n;
    fetch_req = fr; fetch_address = fa;
    data_req = dr; data_write_en = dwe; data_address = da; data_write_value = dwv;
    @(negedge clock);
    chk({tag, ".fetch_grant"},  32'(fetch_grant),  32'(eg[0]));
    chk({tag, ".data_grant"},   32'(data_grant),   32'(eg[1]));
    chk({tag, ".mem_en"},       32'(mem_en),       32'(|eg));
    chk({tag, ".mem_write_en"}, 32'(mem_write_en), 32'(eg[1] & dwe));
    if (eg != 2'b00) chk({tag, ".mem_address"}, mem_address, eg[1] ? da : fa);
    if (eg[1] && dwe) chk({tag, ".mem_write_value"}, mem_write_value, dwv);
    if (sbq.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s.scoreboard: observed empty queue expected entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".fetch_valid"},     32'(fetch_valid), 32'(e.fv));
      chk({tag, ".fetch_data"},      fetch_data,       e.fd);
      chk({tag, ".data_valid"},      32'(data_valid),  32'(e.dv));
      chk({tag, ".data_read_value"}, data_read_value,  e.dd);
    end
    n.fv = (eg == 2'b01);
    n.fd = (eg == 2'b01) ? ed : '0;
    n.dv = (eg == 2'b10);
    n.dd = (eg == 2'b10 && !dwe) ? ed : '0;
    sbq.push_back(n);
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    fetch_req = 1'b1; data_req = 1'b1; data_write_en = 1'b1;
    fetch_address = 32'h10; data_address = 32'h20; data_write_value = 32'hFFFF_FFFF;
    #12;
    chk_all_zero("reset_hold");
    @(posedge clock); #1;
    reset = 1'b0;
    fetch_req = 1'b0; data_req = 1'b0; data_write_en = 1'b0;
    sbq.delete();
    push_idle();

    // Contention straight out of reset: data wins first, then alternation.
    step("rr0", 1, 32'h30, 1, 0, 32'h40, 0, 2'b10, 32'hC0FFEE40);
    step("rr1", 1, 32'h30, 1, 0, 32'h40, 0, 2'b01, 32'hC0FFEE30);
    step("rr2", 1, 32'h30, 1, 0, 32'h40, 0, 2'b10, 32'hC0FFEE40);
    step("rr3", 1, 32'h30, 1, 0, 32'h40, 0, 2'b01, 32'hC0FFEE30);
    step("rr_idle", 0, 0, 0, 0, 0, 0, 2'b00, 0);

    step("fetch0", 1, 32'h10, 0, 0, 0, 0, 2'b01, 32'hDEADBEEF);
    step("fetch_idle", 0, 0, 0, 0, 0, 0, 2'b00, 0);

    step("wr", 0, 0, 1, 1, 32'h20, 32'h12345678, 2'b10, 0);
    step("rd", 0, 0, 1, 0, 32'h20, 0, 2'b10, 32'h12345678);
    step("wr_idle", 0, 0, 0, 0, 0, 0, 2'b00, 0);

    // last_grant is DATA here, so the tie goes to fetch; data then drops.
    step("drop0", 1, 32'h50, 1, 0, 32'h60, 0, 2'b01, 32'hC0FFEE50);
    step("drop1", 1, 32'h54, 0, 0, 32'h60, 0, 2'b01, 32'hC0FFEE54);
    step("drop_idle", 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step("drop_tie", 1, 32'h58, 1, 0, 32'h60, 0, 2'b10, 32'hC0FFEE60);
    step("drop_idle2", 0, 0, 0, 0, 0, 0, 2'b00, 0);

    // Reset in the response cycle of a fetch discards the response.
    step("mid_fetch", 1, 32'h10, 0, 0, 0, 0, 2'b01, 32'hDEADBEEF);
    fetch_req = 1'b1; data_req = 1'b1;
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    fetch_req = 1'b0; data_req = 1'b0;
    sbq.delete();
    push_idle();
    step("post_reset_idle", 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step("post_reset_tie", 1, 32'h30, 1, 0, 32'h60, 0, 2'b10, 32'hC0FFEE60);
    step("post_reset_idle2", 0, 0, 0, 0, 0, 0, 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
